// File: rtl/shift_pkg.sv
// Shared constants for the shift/add triple decoder: FSM encoding and the
// shift amount the upstream encoder uses.
package shift_pkg;

  localparam int SHAMT = 2;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CALC_A = 3'd1;
  localparam logic [2:0] CALC_B = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 INC,
  output logic [CNT_WIDTH-1:0] COUNT
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (INC && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign COUNT = count_q;

endmodule

// File: rtl/shift_unpack.sv
// Decodes an {A>>SHAMT, B<<SHAMT, A+B} triple back into A and B, flagging
// triples no operand pair could have produced.
//
// state  | meaning
// IDLE   | ready for a triple, captures on IN_VALID
// CALC_A | rebuild A from the shifted word and the low sum bits
// CALC_B | B = sum - A, kept one bit wide to catch overflow
// CHECK  | consistency check, register outputs, count errors
// DONE   | hold result until OUT_READY
module shift_unpack
  import shift_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [WIDTH:0]       IN1,
  input  logic [WIDTH:0]       IN2,
  input  logic [WIDTH:0]       IN3,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [WIDTH-1:0]     A_OUT,
  output logic [WIDTH-1:0]     B_OUT,
  output logic                 ERR,
  output logic [CNT_WIDTH-1:0] ERR_CNT
);

  logic [2:0]       state_q, state_d;
  logic [WIDTH:0]   in1_q, in1_d;
  logic [WIDTH:0]   in2_q, in2_d;
  logic [WIDTH:0]   in3_q, in3_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH:0]   diff_q, diff_d;
  logic [WIDTH-1:0] a_out_q, a_out_d;
  logic [WIDTH-1:0] b_out_q, b_out_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [SHAMT-1:0] a_lo;
  logic             chk_err;
  logic             err_inc;

  // B's low bits are visible in IN2, so A's low bits fall out of the sum.
  assign a_lo = in3_q[SHAMT-1:0] - in2_q[2*SHAMT-1:SHAMT];

  assign chk_err = (in1_q[WIDTH:WIDTH-SHAMT] != '0)
                || (in2_q[SHAMT-1:0] != '0)
                || diff_q[WIDTH]
                || (diff_q[WIDTH-SHAMT:0] != in2_q[WIDTH:SHAMT]);

  assign err_inc = (state_q == CHECK) && chk_err;

  always_comb begin
    state_d     = state_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    in3_d       = in3_q;
    a_d         = a_q;
    diff_d      = diff_q;
    a_out_d     = a_out_q;
    b_out_d     = b_out_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID && in_ready_q) begin
          in1_d   = IN1;
          in2_d   = IN2;
          in3_d   = IN3;
          state_d = CALC_A;
        end
      end
      CALC_A: begin
        a_d     = {in1_q[WIDTH-SHAMT-1:0], a_lo};
        state_d = CALC_B;
      end
      CALC_B: begin
        diff_d  = in3_q - {1'b0, a_q};
        state_d = CHECK;
      end
      CHECK: begin
        a_out_d     = a_q;
        b_out_d     = diff_q[WIDTH-1:0];
        err_d       = chk_err;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Registered ready: low for the first cycle out of reset.
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      in1_q       <= '0;
      in2_q       <= '0;
      in3_q       <= '0;
      a_q         <= '0;
      diff_q      <= '0;
      a_out_q     <= '0;
      b_out_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      in3_q       <= in3_d;
      a_q         <= a_d;
      diff_q      <= diff_d;
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_err_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .INC   (err_inc),
    .COUNT (ERR_CNT)
  );

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign A_OUT     = a_out_q;
  assign B_OUT     = b_out_q;
  assign ERR       = err_q;

endmodule

// File: doc/shift_unpack.md
Name: shift_unpack

Overview:
- Receive-side decoder for the registered shift/add encoder word triple. Input is {A>>2, B<<2 truncated, A+B}, each WIDTH+1 bits.
- Reconstructs the original A and B operands over a small multi-cycle FSM.
- Flags triples that no valid (A,B) pair could have produced, and keeps a saturating error count.
- Sits downstream of the encoder, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand width of A and B; input words are WIDTH+1 bits; legal values are >= 4.
- CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  input triple valid.
- IN_READY  output  1  block can accept a triple.
- IN1  input  WIDTH+1  encoded A>>2.
- IN2  input  WIDTH+1  encoded B<<2, truncated to WIDTH+1 bits.
- IN3  input  WIDTH+1  encoded A+B.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts the result.
- A_OUT  output  WIDTH  recovered A.
- B_OUT  output  WIDTH  recovered B.
- ERR  output  1  triple inconsistent; qualified by OUT_VALID.
- ERR_CNT  output  CNT_WIDTH  saturating count of inconsistent triples.

Behaviour:
- Reset (RST low, asynchronous):
  - State goes to IDLE.
  - IN_READY=0 while RST is low, then 1 in IDLE.
  - OUT_VALID=0, A_OUT=0, B_OUT=0, ERR=0, ERR_CNT=0.
  - All capture registers are cleared.
- States: IDLE, CALC_A, CALC_B, CHECK, DONE.
- IDLE:
  - IN_READY=1 (registered, true only in IDLE).
  - On an edge with IN_VALID=1: capture IN1/IN2/IN3 into internal registers and go to CALC_A.
- CALC_A, one cycle:
  - a[WIDTH-1:2] = in1[WIDTH-3:0].
  - a[1:0] = (in3[1:0] - in2[3:2]) mod 4.
  - Go to CALC_B.
- CALC_B, one cycle:
  - diff = in3 - {1'b0,a}, WIDTH+1 bits, modular.
  - b = diff[WIDTH-1:0].
  - Go to CHECK.
- CHECK, one cycle:
  - err = 1 if any of the following holds:
    - in1[WIDTH:WIDTH-2] != 0
    - in2[1:0] != 0
    - diff[WIDTH] != 0
    - diff[WIDTH-2:0] != in2[WIDTH:2]
  - Register A_OUT=a, B_OUT=b, ERR=err.
  - Set OUT_VALID=1.
  - If err=1, ERR_CNT increments, saturating at all-ones (no wrap).
  - Go to DONE.
- Latency: capture at edge k; OUT_VALID is high after edge k+3. Minimum 5 cycles per triple.
- DONE:
  - OUT_VALID=1. A_OUT, B_OUT and ERR are held stable until an edge with OUT_READY=1.
  - On that edge: OUT_VALID=0, go to IDLE.
  - A_OUT, B_OUT and ERR keep their last values after leaving DONE.
  - IN_READY stays 0 throughout DONE, so the block applies backpressure.
- IN_VALID in any state other than IDLE is ignored. The source must hold the triple until IN_READY=1.
- Reset asserted mid-operation aborts the current triple. No output is produced for it, and ERR_CNT returns to 0.
- ERR=1 still presents the computed A_OUT/B_OUT; these values are don't-care for checking purposes.

Decomposition:
- Shared package shift_pkg:
  - State encoding localparams: IDLE=0, CALC_A=1, CALC_B=2, CHECK=3, DONE=4, 3-bit.
  - Shift amount constant SHAMT=2.
  - The encoder's shift amount is retargeted to SHAMT.
- One natural sub-module, sat_counter (parameter CNT_WIDTH, inputs CLK, RST, INC; output COUNT). It provides ERR_CNT.
- Everything else stays in one always-block FSM plus datapath registers.

Test Plan:
- WIDTH=8, IN1=0x02D, IN2=0x170, IN3=0x113 → after 4 edges: A_OUT=0xB7, B_OUT=0x5C, ERR=0, ERR_CNT=0.
- Lost B top bits: IN1=0x000, IN2=0x1FC, IN3=0x102 → A_OUT=0x03, B_OUT=0xFF, ERR=0.
- Corrupted inputs:
  - IN1=0x100, IN2=0x170, IN3=0x113 → ERR=1, ERR_CNT=1.
  - Then IN2=0x171 with IN1=0x02D → ERR=1, ERR_CNT=2.
- Backpressure: hold OUT_READY=0 for 6 cycles after OUT_VALID rises.
  - Outputs stay stable, IN_READY stays 0, and a new IN_VALID is not captured.
  - Release OUT_READY → return to IDLE with IN_READY=1.
- Saturation: CNT_WIDTH=2, send 5 erroneous triples → ERR_CNT sequence 1,2,3,3,3.
- Reset mid-op: drop RST in CALC_B → OUT_VALID=0 and all outputs 0 immediately. After release, all-zero triple → A_OUT=0, B_OUT=0, ERR=0.
